// File: rtl/mt_pulse_generator_if.sv
// Control, table-write and status signals of the moving-target pulse generator.
interface mt_pulse_generator_if #(
  parameter int unsigned POS_W  = 16,
  parameter int unsigned LEN_W  = 8,
  parameter int unsigned ADDR_W = 3
);
  logic              EN;
  logic              TRIG;
  logic              USEC;
  logic              WR_EN;
  logic [ADDR_W-1:0] WR_ADDR;
  logic [POS_W-1:0]  WR_POS;
  logic [LEN_W-1:0]  WR_LEN;
  logic              COMMIT;
  logic              OVR_CLR;
  logic              GEN_SIGNAL;
  logic              BUSY;
  logic              SWEEP_DONE;
  logic              OVERRUN;
  logic [POS_W-1:0]  RANGE_CNT;

  // Controller / timing-source side
  modport master (
    output EN, TRIG, USEC, WR_EN, WR_ADDR, WR_POS, WR_LEN, COMMIT, OVR_CLR,
    input  GEN_SIGNAL, BUSY, SWEEP_DONE, OVERRUN, RANGE_CNT
  );

  // Generator side
  modport slave (
    input  EN, TRIG, USEC, WR_EN, WR_ADDR, WR_POS, WR_LEN, COMMIT, OVR_CLR,
    output GEN_SIGNAL, BUSY, SWEEP_DONE, OVERRUN, RANGE_CNT
  );
endinterface

// File: rtl/mt_pulse_generator.sv
// Programmable moving-target pulse generator: double-buffered target table,
// microsecond range counter started by TRIG, GEN_SIGNAL high inside any window.
module mt_pulse_generator #(
  parameter int unsigned SIZE        = 3200,
  parameter int unsigned MAX_TARGETS = 8,
  parameter int unsigned POS_W       = 16,
  parameter int unsigned LEN_W       = 8,
  parameter int unsigned ADDR_W      = (MAX_TARGETS > 1) ? $clog2(MAX_TARGETS) : 1
) (
  input logic                 SYS_CLK,
  input logic                 SYS_RESETN,
  mt_pulse_generator_if.slave bus
);

  localparam int unsigned      SUM_W    = POS_W + 1;
  localparam logic [POS_W-1:0] LAST_CNT = POS_W'(SIZE - 1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [POS_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              ovr_q, ovr_d;
  logic              gen_q, gen_d;
  logic              trig_q, usec_q;
  logic              sel_q, pending_q;
  logic              trig_edge, usec_edge, trig_acc, swap, wr_ok, any_hit;

  logic [POS_W-1:0]  pos_tbl [2][MAX_TARGETS];
  logic [LEN_W-1:0]  len_tbl [2][MAX_TARGETS];

  assign trig_edge = bus.TRIG & ~trig_q;
  assign usec_edge = bus.USEC & ~usec_q;
  assign trig_acc  = bus.EN & trig_edge;
  assign swap      = trig_acc & (pending_q | bus.COMMIT);
  assign wr_ok     = bus.WR_EN && (32'(bus.WR_ADDR) < MAX_TARGETS);

  assign bus.GEN_SIGNAL = gen_q;
  assign bus.BUSY       = busy_q;
  assign bus.SWEEP_DONE = done_q;
  assign bus.OVERRUN    = ovr_q;
  assign bus.RANGE_CNT  = cnt_q;

  // Input edge-detect delay flops
  always_ff @(posedge SYS_CLK) begin
    if (!SYS_RESETN) begin
      trig_q <= 1'b0;
      usec_q <= 1'b0;
    end else begin
      trig_q <= bus.TRIG;
      usec_q <= bus.USEC;
    end
  end

  // Shadow-bank writes; the pre-swap shadow is written even on a swap cycle
  always_ff @(posedge SYS_CLK) begin
    if (!SYS_RESETN) begin
      pos_tbl <= '{default: '0};
      len_tbl <= '{default: '0};
    end else if (wr_ok) begin
      pos_tbl[~sel_q][bus.WR_ADDR] <= bus.WR_POS;
      len_tbl[~sel_q][bus.WR_ADDR] <= bus.WR_LEN;
    end
  end

  // Bank select and pending commit; swaps only on an accepted trigger
  always_ff @(posedge SYS_CLK) begin
    if (!SYS_RESETN) begin
      sel_q     <= 1'b0;
      pending_q <= 1'b0;
    end else if (swap) begin
      sel_q     <= ~sel_q;
      pending_q <= 1'b0;
    end else if (bus.COMMIT) begin
      pending_q <= 1'b1;
    end
  end

  // Window hit against the active bank; sum widened so windows never wrap
  always_comb begin
    any_hit = 1'b0;
    for (int unsigned i = 0; i < MAX_TARGETS; i++) begin
      if ((len_tbl[sel_q][ADDR_W'(i)] != '0) &&
          (cnt_q >= pos_tbl[sel_q][ADDR_W'(i)]) &&
          (SUM_W'(cnt_q) < (SUM_W'(pos_tbl[sel_q][ADDR_W'(i)]) +
                            SUM_W'(len_tbl[sel_q][ADDR_W'(i)])))) begin
        any_hit = 1'b1;
      end
    end
  end

  // Sweep FSM next-state and registered-output values
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    ovr_d   = ovr_q;
    if (bus.OVR_CLR) begin
      ovr_d = 1'b0;
    end
    case (state_q)
      IDLE: begin
        if (trig_acc) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (!bus.EN) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (trig_edge) begin
          cnt_d = '0;
          ovr_d = 1'b1;
        end else if (usec_edge) begin
          if (cnt_q == LAST_CNT) begin
            state_d = IDLE;
            cnt_d   = '0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + POS_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
    gen_d  = (state_q == RUN) && (state_d == RUN) && any_hit;
  end

  // State and output registers
  always_ff @(posedge SYS_CLK) begin
    if (!SYS_RESETN) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
      gen_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
      gen_q   <= gen_d;
    end
  end

endmodule

// File: tb/tb_mt_pulse_generator.sv
// Bench for mt_pulse_generator: GEN_SIGNAL edges and SWEEP_DONE pulses are
// scoreboarded against queued expectations; status outputs checked directly.
module tb_mt_pulse_generator;

  localparam int unsigned POS_W  = 16;
  localparam int unsigned LEN_W  = 8;
  localparam int unsigned ADDR_W = 3;

  localparam int EV_RISE = 0;
  localparam int EV_FALL = 1;
  localparam int EV_DONE = 2;

  typedef struct {
    int kind;
    int cnt;
  } ev_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic gen_prev;
  ev_t  exp_q[$];

  mt_pulse_generator_if #(.POS_W(POS_W), .LEN_W(LEN_W), .ADDR_W(ADDR_W)) bus ();

  mt_pulse_generator #(
    .SIZE(3200), .MAX_TARGETS(8), .POS_W(POS_W), .LEN_W(LEN_W), .ADDR_W(ADDR_W)
  ) dut (
    .SYS_CLK    (clk),
    .SYS_RESETN (rst_n),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input int kind, input int cnt);
    ev_t e;
    e.kind = kind;
    e.cnt  = cnt;
    exp_q.push_back(e);
  endtask

  task automatic usec_ticks(input int n);
    for (int k = 0; k < n; k++) begin
      bus.USEC = 1'b1;
      tick();
      bus.USEC = 1'b0;
      tick();
    end
  endtask

  task automatic trig_pulse();
    bus.TRIG = 1'b1;
    tick();
    bus.TRIG = 1'b0;
    tick();
  endtask

  task automatic wr(input int addr, input int pos, input int len);
    bus.WR_EN   = 1'b1;
    bus.WR_ADDR = ADDR_W'(addr);
    bus.WR_POS  = POS_W'(pos);
    bus.WR_LEN  = LEN_W'(len);
    tick();
    bus.WR_EN = 1'b0;
  endtask

  task automatic commit();
    bus.COMMIT = 1'b1;
    tick();
    bus.COMMIT = 1'b0;
  endtask

  // Monitor: compare each observed output event against the queue head
  task automatic observe(input int kind, input int cnt);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL event: unexpected kind %0d at count %0d, expected none", kind, cnt);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.cnt != cnt) begin
        errors++;
        $display("FAIL event: got kind %0d count %0d expected kind %0d count %0d",
                 kind, cnt, e.kind, e.cnt);
      end
    end
  endtask

  initial gen_prev = 1'b0;

  always @(negedge clk) begin
    if (bus.GEN_SIGNAL === 1'b1 && gen_prev === 1'b0) observe(EV_RISE, int'(bus.RANGE_CNT));
    if (bus.GEN_SIGNAL === 1'b0 && gen_prev === 1'b1) observe(EV_FALL, int'(bus.RANGE_CNT));
    if (bus.SWEEP_DONE === 1'b1) observe(EV_DONE, int'(bus.RANGE_CNT));
    gen_prev = bus.GEN_SIGNAL;
  end

  initial begin
    checks      = 0;
    errors      = 0;
    rst_n       = 1'b0;
    bus.EN      = 1'b1;
    bus.TRIG    = 1'b0;
    bus.USEC    = 1'b0;
    bus.WR_EN   = 1'b0;
    bus.WR_ADDR = '0;
    bus.WR_POS  = '0;
    bus.WR_LEN  = '0;
    bus.COMMIT  = 1'b0;
    bus.OVR_CLR = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    chk("reset_gen",  32'(bus.GEN_SIGNAL), 32'd0);
    chk("reset_busy", 32'(bus.BUSY),       32'd0);
    chk("reset_done", 32'(bus.SWEEP_DONE), 32'd0);
    chk("reset_ovr",  32'(bus.OVERRUN),    32'd0);
    chk("reset_cnt",  32'(bus.RANGE_CNT),  32'd0);

    // Shadow write without commit: empty active bank, no pulse; mid-sweep commit
    wr(0, 100, 4);
    trig_pulse();
    usec_ticks(200);
    commit();
    push(EV_DONE, 0);
    usec_ticks(3000);
    tick();
    chk("nocommit_busy_after", 32'(bus.BUSY), 32'd0);

    // Pending commit applied at next trigger, then restart at 1500
    push(EV_RISE, 100);
    push(EV_FALL, 104);
    trig_pulse();
    chk("sweep_busy", 32'(bus.BUSY), 32'd1);
    usec_ticks(1500);
    chk("cnt_before_restart", 32'(bus.RANGE_CNT), 32'd1500);
    bus.TRIG = 1'b1;
    tick();
    chk("restart_cnt",  32'(bus.RANGE_CNT), 32'd0);
    chk("restart_ovr",  32'(bus.OVERRUN),   32'd1);
    chk("restart_busy", 32'(bus.BUSY),      32'd1);
    bus.TRIG = 1'b0;
    tick();
    push(EV_RISE, 100);
    push(EV_FALL, 104);
    push(EV_DONE, 0);
    usec_ticks(3200);
    tick();
    chk("ovr_sticky", 32'(bus.OVERRUN), 32'd1);
    bus.OVR_CLR = 1'b1;
    tick();
    bus.OVR_CLR = 1'b0;
    chk("ovr_cleared", 32'(bus.OVERRUN), 32'd0);

    // Eight targets of three ticks each
    for (int i = 0; i < 8; i++) wr(i, 300 + 400 * i, 3);
    commit();
    for (int i = 0; i < 8; i++) begin
      push(EV_RISE, 300 + 400 * i);
      push(EV_FALL, 303 + 400 * i);
    end
    push(EV_DONE, 0);
    trig_pulse();
    usec_ticks(3200);
    tick();
    chk("pattern_busy_after", 32'(bus.BUSY),      32'd0);
    chk("pattern_cnt_after",  32'(bus.RANGE_CNT), 32'd0);

    // Window truncated at sweep end; zero-length entry never fires
    wr(0, 3198, 10);
    wr(1, 5, 0);
    commit();
    push(EV_RISE, 3198);
    push(EV_FALL, 0);
    push(EV_DONE, 0);
    trig_pulse();
    usec_ticks(3200);
    usec_ticks(20);
    chk("idle_no_advance_cnt", 32'(bus.RANGE_CNT), 32'd0);
    chk("idle_no_advance_busy", 32'(bus.BUSY),     32'd0);

    // EN dropped mid-sweep, then TRIG while disabled
    commit();
    push(EV_RISE, 300);
    push(EV_FALL, 303);
    trig_pulse();
    usec_ticks(500);
    bus.EN = 1'b0;
    tick();
    chk("disable_busy", 32'(bus.BUSY),       32'd0);
    chk("disable_cnt",  32'(bus.RANGE_CNT),  32'd0);
    chk("disable_gen",  32'(bus.GEN_SIGNAL), 32'd0);
    trig_pulse();
    chk("disabled_trig_busy", 32'(bus.BUSY), 32'd0);
    usec_ticks(10);
    bus.EN = 1'b1;
    tick();

    // Reset while GEN_SIGNAL is high clears output and table
    push(EV_RISE, 300);
    trig_pulse();
    usec_ticks(301);
    chk("pre_reset_gen", 32'(bus.GEN_SIGNAL), 32'd1);
    push(EV_FALL, 0);
    rst_n = 1'b0;
    tick();
    chk("midreset_gen",  32'(bus.GEN_SIGNAL), 32'd0);
    chk("midreset_busy", 32'(bus.BUSY),       32'd0);
    rst_n = 1'b1;
    tick();
    trig_pulse();
    usec_ticks(400);
    chk("post_reset_busy", 32'(bus.BUSY), 32'd1);

    repeat (4) tick();
    chk("events_outstanding", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
